// File: rtl/seven_seg_scan_if.sv
// Bus between the display source (master) and the seven-segment scan controller (slave).
// The controller is the slave: it samples the live data and drives the frame-stable outputs.
interface seven_seg_scan_if;
    logic [31:0] display_in;
    logic [1:0]  sw_in;
    logic        load_now;
    logic [3:0]  blink_mask;
    logic [1:0]  scanning;
    logic [31:0] display_code;
    logic [1:0]  sw;
    logic        frame_tick;
    logic        blank;

    modport master (
        output display_in,
        output sw_in,
        output load_now,
        output blink_mask,
        input  scanning,
        input  display_code,
        input  sw,
        input  frame_tick,
        input  blank
    );

    modport slave (
        input  display_in,
        input  sw_in,
        input  load_now,
        input  blink_mask,
        output scanning,
        output display_code,
        output sw,
        output frame_tick,
        output blank
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Digit-scan divider for a 4-digit seven-segment display. Display data and switch
// selects are latched at frame boundaries (or on load_now) so a digit never tears.
module seven_seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 128,
    parameter int unsigned CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);

    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   DivLast   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRAME_W-1:0] FrameLast = FRAME_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]   div_q, div_d;
    logic [1:0]         scan_q, scan_d;
    logic [31:0]        code_q, code_d;
    logic [1:0]         sw_q, sw_d;
    logic [1:0]         sw_meta_q, sw_sync_q;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               phase_q, phase_d;
    logic               tick_q, tick_d;
    logic               blank_q, blank_d;

    logic slot_end;
    logic frame_end;
    logic capture;

    assign slot_end  = (div_q == DivLast);
    assign frame_end = slot_end && (scan_q == 2'd3);
    assign capture   = frame_end || bus.load_now;

    always_comb begin
        div_d   = div_q;
        scan_d  = scan_q;
        code_d  = code_q;
        sw_d    = sw_q;
        frame_d = frame_q;
        phase_d = phase_q;

        if (slot_end) begin
            div_d  = '0;
            scan_d = scan_q + 2'd1;
        end else begin
            div_d = div_q + CNT_W'(1);
        end

        if (capture) begin
            code_d = bus.display_in;
            sw_d   = sw_sync_q;
        end

        if (frame_end) begin
            if (frame_q == FrameLast) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end

        tick_d = frame_end;
        // Next-state scan and phase keep blank aligned with the digit it applies to.
        blank_d = phase_d & bus.blink_mask[scan_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            scan_q    <= '0;
            code_q    <= '0;
            sw_q      <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            frame_q   <= '0;
            phase_q   <= 1'b0;
            tick_q    <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            scan_q    <= scan_d;
            code_q    <= code_d;
            sw_q      <= sw_d;
            sw_meta_q <= bus.sw_in;
            sw_sync_q <= sw_meta_q;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            tick_q    <= tick_d;
            blank_q   <= blank_d;
        end
    end

    assign bus.scanning     = scan_q;
    assign bus.display_code = code_q;
    assign bus.sw           = sw_q;
    assign bus.frame_tick   = tick_q;
    assign bus.blank        = blank_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=4, BLINK_FRAMES=2.
// Cycle k = state observed 1 time unit after the k-th rising edge following reset release.
module tb_seven_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seven_seg_scan_if bus ();

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2),
        .CNT_W       (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.display_in     = '0;
        bus.sw_in          = '0;
        bus.load_now       = 1'b0;
        bus.blink_mask     = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s scanning", tag), 32'(bus.scanning), 32'd0);
        chk($sformatf("%s display_code", tag), bus.display_code, 32'd0);
        chk($sformatf("%s sw", tag), 32'(bus.sw), 32'd0);
        chk($sformatf("%s frame_tick", tag), 32'(bus.frame_tick), 32'd0);
        chk($sformatf("%s blank", tag), 32'(bus.blank), 32'd0);
    endtask

    initial begin
        bus.display_in = '0;
        bus.sw_in      = '0;
        bus.load_now   = 1'b0;
        bus.blink_mask = '0;

        // Reset state
        #2;
        chk_all_zero("reset");

        // Scan sequence, frame-latched data and switches
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            chk($sformatf("scan c%0d", k), 32'(bus.scanning), 32'((k / 4) % 4));
            chk($sformatf("tick c%0d", k), 32'(bus.frame_tick), 32'(k == 16));
            chk($sformatf("code c%0d", k), bus.display_code,
                (k >= 16) ? 32'hFFFF_0000 : 32'h0);
            chk($sformatf("sw c%0d", k), 32'(bus.sw), (k >= 16) ? 32'd2 : 32'd0);
            chk($sformatf("blank c%0d", k), 32'(bus.blank), 32'd0);
            if (k == 3) bus.sw_in = 2'b10;
            if (k == 5) bus.display_in = 32'h1234_ABCD;
            if (k == 10) bus.display_in = 32'hFFFF_0000;
            step();
        end

        // load_now mid-frame capture
        do_reset();
        bus.sw_in = 2'b01;
        for (int k = 0; k <= 17; k++) begin
            chk($sformatf("ld scan c%0d", k), 32'(bus.scanning), 32'((k / 4) % 4));
            chk($sformatf("ld tick c%0d", k), 32'(bus.frame_tick), 32'(k == 16));
            chk($sformatf("ld code c%0d", k), bus.display_code,
                (k >= 7) ? 32'hDEAD_BEEF : 32'h0);
            chk($sformatf("ld sw c%0d", k), 32'(bus.sw), (k >= 7) ? 32'd1 : 32'd0);
            if (k == 6) begin
                bus.load_now   = 1'b1;
                bus.display_in = 32'hDEAD_BEEF;
            end
            if (k == 7) bus.load_now = 1'b0;
            step();
        end

        // Blink: frames 2-3 blank digits 0 and 2
        do_reset();
        bus.blink_mask = 4'b0101;
        for (int k = 0; k < 96; k++) begin
            int frame;
            int digit;
            frame = (k / 16) % 4;
            digit = (k / 4) % 4;
            chk($sformatf("blank f%0d c%0d", k / 16, k), 32'(bus.blank),
                32'((frame >= 2) && (digit == 0 || digit == 2)));
            step();
        end

        // Mid-frame reset, then load_now coinciding with a frame boundary
        do_reset();
        bus.display_in = 32'h5555_AAAA;
        bus.sw_in      = 2'b11;
        for (int k = 0; k <= 11; k++) begin
            if (k == 3) bus.load_now = 1'b1;
            if (k == 4) bus.load_now = 1'b0;
            if (k < 11) step();
        end
        chk("pre-rst scan", 32'(bus.scanning), 32'd2);
        chk("pre-rst code", bus.display_code, 32'h5555_AAAA);
        chk("pre-rst sw", 32'(bus.sw), 32'd3);
        rst = 1'b1;
        #1;
        chk_all_zero("mid-frame rst");
        step();
        rst = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            chk($sformatf("rr scan c%0d", k), 32'(bus.scanning), 32'((k / 4) % 4));
            chk($sformatf("rr tick c%0d", k), 32'(bus.frame_tick), 32'(k == 16));
            chk($sformatf("rr code c%0d", k), bus.display_code,
                (k >= 16) ? 32'hCAFE_F00D : 32'h0);
            chk($sformatf("rr sw c%0d", k), 32'(bus.sw), (k >= 16) ? 32'd3 : 32'd0);
            if (k == 15) begin
                bus.load_now   = 1'b1;
                bus.display_in = 32'hCAFE_F00D;
            end
            if (k == 16) bus.load_now = 1'b0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
